// File: rtl/rec_pkg.sv
// Shared constants and types for the note recorder and the staff renderer.
package rec_pkg;

  localparam int unsigned SLOTS        = 160;
  localparam int unsigned NOTE_W       = 6;
  localparam int unsigned PERIOD_W     = 27;
  localparam int unsigned SLOT_W       = 8;

  // Note word layout: bit 5 = sounding, bits 4:0 = pitch index.
  localparam int unsigned SOUND_BIT    = 5;
  localparam int unsigned PITCH_LSB    = 0;
  localparam int unsigned PITCH_W      = 5;

  localparam logic [NOTE_W-1:0] REST   = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNTIN = 2'd1,
    ST_RECORD  = 2'd2,
    ST_DONE    = 2'd3
  } rec_state_e;

  typedef struct packed {
    logic               sounding;
    logic [PITCH_W-1:0] pitch;
  } note_t;

  function automatic logic [NOTE_W-1:0] make_note(input logic [PITCH_W-1:0] pitch);
    note_t n;
    n.sounding = 1'b1;
    n.pitch    = pitch;
    return NOTE_W'(n);
  endfunction

  function automatic logic is_sounding(input logic [NOTE_W-1:0] word);
    return word[SOUND_BIT];
  endfunction

endpackage

// File: rtl/eighth_timer.sv
// Eighth-note timebase: counts 0..period-1, flags the last cycle, tracks eighth parity.
module eighth_timer
  import rec_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick_c,
  output logic                parity
);

  logic [PERIOD_W-1:0] cnt_q;

  assign tick_c = run && (cnt_q == (period - PERIOD_W'(1)));

  // parity is the parity of the eighth currently being timed (0 = even)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      cnt_q  <= '0;
      parity <= 1'b0;
    end else if (tick_c) begin
      cnt_q  <= '0;
      parity <= ~parity;
    end else if (run) begin
      cnt_q  <= cnt_q + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/note_recorder.sv
// Records detected notes into an eighth-note score after a one-measure count-in.
module note_recorder #(
  parameter int unsigned SLOTS           = rec_pkg::SLOTS,
  parameter int unsigned NOTE_W          = rec_pkg::NOTE_W,
  parameter int unsigned COUNTIN_EIGHTHS = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    stop_in,
  input  logic [26:0]             period_in,
  input  logic                    note_valid_in,
  input  logic [NOTE_W-1:0]       note_in,
  output logic [SLOTS*NOTE_W-1:0] notes_out,
  output logic [7:0]              slot_out,
  output logic                    click_out,
  output logic [1:0]              state_out,
  output logic                    done_out
);

  import rec_pkg::*;

  localparam int unsigned CIN_W = (COUNTIN_EIGHTHS > 1) ? $clog2(COUNTIN_EIGHTHS) : 1;
  localparam logic [CIN_W-1:0]  CIN_LAST  = CIN_W'(COUNTIN_EIGHTHS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [NOTE_W-1:0] NOTE_REST = NOTE_W'(REST);

  rec_state_e             state_q;
  logic [SLOTS*NOTE_W-1:0] notes_q;
  logic [SLOT_W-1:0]      slot_q;
  logic [PERIOD_W-1:0]    period_q;
  logic [CIN_W-1:0]       cin_q;
  logic [NOTE_W-1:0]      cap_q;
  logic                   click_q;
  logic                   done_q;

  logic                   run_c;
  logic                   tick_c;
  logic                   parity;
  logic [NOTE_W-1:0]      slot_word_c;

  assign run_c = (state_q == ST_COUNTIN) || (state_q == ST_RECORD);

  eighth_timer u_timer (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .clear  (start_in),
    .run    (run_c),
    .period (period_q),
    .tick_c (tick_c),
    .parity (parity)
  );

  // A strobe on the closing tick still belongs to this window.
  assign slot_word_c = note_valid_in ? note_in : cap_q;

  // Main sequencer; start_in overrides everything, then stop_in, then tick.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      notes_q  <= '0;
      slot_q   <= '0;
      period_q <= '0;
      cin_q    <= '0;
      cap_q    <= NOTE_REST;
      click_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      click_q <= 1'b0;
      done_q  <= 1'b0;
      if (start_in) begin
        state_q  <= ST_COUNTIN;
        notes_q  <= '0;
        slot_q   <= '0;
        period_q <= period_in;
        cin_q    <= '0;
        cap_q    <= NOTE_REST;
        click_q  <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            cap_q <= NOTE_REST;
          end
          ST_COUNTIN: begin
            if (stop_in) begin
              state_q <= ST_IDLE;
              notes_q <= '0;
            end else if (tick_c) begin
              // a click starts every even eighth, i.e. after an odd one closes
              click_q <= parity;
              if (cin_q == CIN_LAST) begin
                state_q <= ST_RECORD;
                slot_q  <= '0;
                cap_q   <= NOTE_REST;
              end else begin
                cin_q <= cin_q + CIN_W'(1);
              end
            end
          end
          ST_RECORD: begin
            if (stop_in) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              cap_q   <= NOTE_REST;
            end else if (tick_c) begin
              notes_q[32'(slot_q)*NOTE_W +: NOTE_W] <= slot_word_c;
              cap_q <= NOTE_REST;
              if (slot_q == SLOT_LAST) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                slot_q  <= slot_q + SLOT_W'(1);
                click_q <= parity;
              end
            end else if (note_valid_in) begin
              cap_q <= note_in;
            end
          end
          ST_DONE: begin
            cap_q <= NOTE_REST;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign notes_out = notes_q;
  assign slot_out  = slot_q;
  assign click_out = click_q;
  assign state_out = 2'(state_q);
  assign done_out  = done_q;

endmodule

// File: tb/tb_note_recorder.sv
// Directed self-checking bench for note_recorder.
module tb_note_recorder;
  import rec_pkg::*;

  localparam int NS = 160;
  localparam int NW = 6;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              start_in = 1'b0;
  logic              stop_in = 1'b0;
  logic [26:0]       period_in = '0;
  logic              note_valid_in = 1'b0;
  logic [NW-1:0]     note_in = '0;
  logic [NS*NW-1:0]  notes_out;
  logic [7:0]        slot_out;
  logic              click_out;
  logic [1:0]        state_out;
  logic              done_out;

  int n_checks = 0;
  int n_errors = 0;

  note_recorder #(.SLOTS(NS), .NOTE_W(NW), .COUNTIN_EIGHTHS(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .period_in     (period_in),
    .note_valid_in (note_valid_in),
    .note_in       (note_in),
    .notes_out     (notes_out),
    .slot_out      (slot_out),
    .click_out     (click_out),
    .state_out     (state_out),
    .done_out      (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // After this returns we are just past the edge that sampled start_in (edge 0).
  task automatic pulse_start(input logic [26:0] p);
    period_in = p;
    start_in  = 1'b1;
    step(1);
    start_in  = 1'b0;
  endtask

  task automatic strobe(input logic [NW-1:0] v);
    note_valid_in = 1'b1;
    note_in       = v;
    step(1);
    note_valid_in = 1'b0;
    note_in       = '0;
  endtask

  function automatic logic [NW-1:0] slot_of(input int k);
    return notes_out[k*NW +: NW];
  endfunction

  function automatic int nonrest_from(input int first);
    int c = 0;
    for (int k = first; k < NS; k++)
      if (notes_out[k*NW +: NW] != '0) c++;
    return c;
  endfunction

  initial begin
    int clicks;
    int edge_n;
    int done_edge;

    // Reset state
    step(2);
    check("rst_state", 32'(state_out), 32'(ST_IDLE));
    check("rst_slot", 32'(slot_out), 0);
    check("rst_notes", 32'(|notes_out), 0);
    check("rst_click", 32'(click_out), 0);
    check("rst_done", 32'(done_out), 0);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    step(2);

    // Full silent take at P=4: count-in 32 cycles, 160 rest slots
    pulse_start(27'd4);
    check("t1_state_cin", 32'(state_out), 32'(ST_COUNTIN));
    check("t1_click_entry", 32'(click_out), 1);
    clicks = 1;
    for (int n = 1; n <= 31; n++) begin
      if (n == 5) strobe(6'b111111);
      else step(1);
      if (click_out) clicks++;
    end
    check("t1_state_edge31", 32'(state_out), 32'(ST_COUNTIN));
    check("t1_countin_clicks", 32'(clicks), 4);
    clicks = 0;
    edge_n = 31;
    done_edge = -1;
    while (edge_n < 1000 && done_edge < 0) begin
      step(1);
      edge_n++;
      if (edge_n == 32) check("t1_record_entry", 32'(state_out), 32'(ST_RECORD));
      if (click_out) clicks++;
      if (done_out) done_edge = edge_n;
    end
    // done_out rises on the 673rd edge counting the start edge as the first
    check("t1_done_edge", 32'(done_edge), 672);
    check("t1_record_clicks", 32'(clicks), 80);
    check("t1_state_done", 32'(state_out), 32'(ST_DONE));
    check("t1_slot_sat", 32'(slot_out), 159);
    check("t1_all_rest", 32'(nonrest_from(0)), 0);
    step(1);
    check("t1_done_pulse", 32'(done_out), 0);
    strobe(6'b100001);
    check("t1_done_ignore", 32'(nonrest_from(0)), 0);

    // Capture: two strobes in slot 0, strobe on slot 3 tick
    pulse_start(27'd4);
    step(32);
    check("t2_record", 32'(state_out), 32'(ST_RECORD));
    strobe(6'b100001);
    strobe(6'b100101);
    step(1);
    check("t2_slot0_pending", 32'(slot_of(0)), 0);
    check("t2_slot_out0", 32'(slot_out), 0);
    step(1);
    check("t2_slot0", 32'(slot_of(0)), 32'h25);
    check("t2_slot_out1", 32'(slot_out), 1);
    step(11);
    strobe(6'b101000);
    check("t2_slot3", 32'(slot_of(3)), 32'h28);
    check("t2_slot_out4", 32'(slot_out), 4);
    check("t2_slot1", 32'(slot_of(1)), 0);
    check("t2_slot2", 32'(slot_of(2)), 0);
    step(4);
    check("t2_slot4", 32'(slot_of(4)), 0);
    check("t2_slot_out5", 32'(slot_out), 5);

    // Early stop mid-window of slot 10
    step(21);
    strobe(6'b100111);
    stop_in = 1'b1;
    step(1);
    stop_in = 1'b0;
    check("t3_state", 32'(state_out), 32'(ST_DONE));
    check("t3_done", 32'(done_out), 1);
    check("t3_slot", 32'(slot_out), 10);
    check("t3_tail_rest", 32'(nonrest_from(10)), 0);
    check("t3_slot3_kept", 32'(slot_of(3)), 32'h28);
    step(20);
    check("t3_hold_state", 32'(state_out), 32'(ST_DONE));
    check("t3_hold_slot0", 32'(slot_of(0)), 32'h25);
    check("t3_hold_done", 32'(done_out), 0);

    // Start and stop together mid-RECORD: restart wins
    pulse_start(27'd4);
    check("t4_cin", 32'(state_out), 32'(ST_COUNTIN));
    check("t4_cleared", 32'(nonrest_from(0)), 0);
    step(32);
    strobe(6'b110000);
    step(3);
    check("t4_slot0", 32'(slot_of(0)), 32'h30);
    step(5);
    start_in = 1'b1;
    stop_in  = 1'b1;
    step(1);
    start_in = 1'b0;
    stop_in  = 1'b0;
    check("t4_restart_state", 32'(state_out), 32'(ST_COUNTIN));
    check("t4_restart_notes", 32'(nonrest_from(0)), 0);
    check("t4_restart_slot", 32'(slot_out), 0);
    check("t4_restart_click", 32'(click_out), 1);
    // Stop during count-in returns to IDLE
    step(5);
    stop_in = 1'b1;
    step(1);
    stop_in = 1'b0;
    check("t4_cin_stop", 32'(state_out), 32'(ST_IDLE));
    check("t4_cin_stop_notes", 32'(nonrest_from(0)), 0);

    // Asynchronous reset mid-RECORD at slot 50
    pulse_start(27'd4);
    step(32);
    strobe(6'b100011);
    step(201);
    check("t5_slot50", 32'(slot_out), 50);
    check("t5_slot0", 32'(slot_of(0)), 32'h23);
    rst_in = 1'b0;
    #2;
    check("t5_rst_state", 32'(state_out), 32'(ST_IDLE));
    check("t5_rst_slot", 32'(slot_out), 0);
    check("t5_rst_notes", 32'(|notes_out), 0);
    check("t5_rst_click", 32'(click_out), 0);
    check("t5_rst_done", 32'(done_out), 0);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    step(1);
    // Restart at the minimum period: RECORD after 16 cycles
    pulse_start(27'd2);
    check("t5_restart", 32'(state_out), 32'(ST_COUNTIN));
    check("t5_restart_click", 32'(click_out), 1);
    step(15);
    check("t5_p2_cin_end", 32'(state_out), 32'(ST_COUNTIN));
    step(1);
    check("t5_p2_record", 32'(state_out), 32'(ST_RECORD));
    check("t5_p2_click", 32'(click_out), 1);
    check("t5_p2_slot", 32'(slot_out), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
